sd4_mac_sequencer: RTL and testbench
====================================

// Module: sd4_mac_sequencer
// PURPOSE
//  Sequences operand windows into the SD4 MAC pipeline. Each window is 9 image and 9 weight lanes feeding the partial-product stage.
//  A job produces N_OUT results; each result accumulates N_GRP consecutive windows.
//  Tags each issued window with valid/first/last and delays the tags to match pipeline latency, giving accumulator controls at the pipe tail.
//  Throttles issue with a result-credit counter, because the MAC pipe itself cannot stall.
// PARAMETERS
//  PIPE_DEPTH  4   cycles from mac_issue to the matching tail-side acc_en/res_valid (>=1)
//  CNT_W       8   width of the group and output counters
//  CREDITS     4   result slots downstream; max results in flight (>=1)
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous reset, active low
//  cfg_valid     in   1      job descriptor valid
//  cfg_ready     out  1      high only in IDLE
//  cfg_groups    in   CNT_W  windows per result; 0 treated as 1
//  cfg_outputs   in   CNT_W  results per job; 0 treated as 1
//  cfg_exp_bias  in   5      exponent bias for the job
//  op_valid      in   1      operand window valid
//  op_ready      out  1      window accepted when op_valid&op_ready
//  op_image      in   72     9 x 8-bit image lanes, lane0 = [71:64]
//  op_weight     in   36     9 x 4-bit weight lanes, lane0 = [35:32]
//  mac_image     out  72     registered to the MAC pipe; all-zero on bubbles
//  mac_weight    out  36     registered to the MAC pipe; all-zero on bubbles
//  mac_exp_bias  out  5      latched job bias, held for the whole job
//  mac_issue     out  1      registered; window presented this cycle
//  acc_clear     out  1      pipe tail: first window of a result (load, do not add)
//  acc_en        out  1      pipe tail: valid window, accumulate
//  res_valid     out  1      pipe tail: last window of a result, result complete
//  res_take      in   1      downstream frees one result slot (returns one credit)
//  busy          out  1      state != IDLE
//  done          out  1      1-cycle pulse when the job is fully drained
// BEHAVIOUR
//  Reset (rst=0 at posedge):
//   - state=IDLE, credits=CREDITS, all counters 0, tag pipe cleared.
//   - All outputs 0 except cfg_ready=1.
//   - Mid-job reset discards in-flight windows; no res_valid appears afterwards.
//  FSM IDLE/RUN/DRAIN:
//   - IDLE: cfg_valid latches groups, outputs, bias -> RUN.
//   - RUN: op_ready = (credits!=0). On the accepted window with grp_cnt==groups-1 and out_cnt==outputs-1 -> DRAIN.
//   - DRAIN: op_ready=0; when the tag pipe is empty -> IDLE with done=1 that cycle.
//  Issue, on each handshake in cycle t, at t+1:
//   - mac_issue=1, mac_image/weight = operands.
//   - mac_first = (grp_cnt==0); mac_last = (grp_cnt==groups-1).
//   - Without a handshake: mac_issue=0, mac_image/weight=0 (zero-detect gives a null product).
//  Counters:
//   - grp_cnt increments per accepted window and wraps to 0 after the last window of a result; out_cnt then increments.
//   - groups=1: every window is both first and last.
//  Credits:
//   - Decrement on acceptance of a last window; increment on res_take.
//   - Both in the same cycle: unchanged.
//   - res_take with credits==CREDITS is ignored (saturate).
//   - Credits persist across jobs and are not reset at job end.
//  Tag pipe: {valid, first, last} shift register of PIPE_DEPTH stages fed from mac_issue/first/last.
//   - acc_en = v, acc_clear = v&f, res_valid = v&l, all taken at the tail stage.
//   - Latency from mac_issue to the tail outputs is exactly PIPE_DEPTH cycles.
//  op_valid with op_ready=0 (IDLE, DRAIN, or credits==0): no acceptance; operands must be held by the source.
//  cfg_valid outside IDLE is ignored.
// STRUCTURE
//  Shared package sd4_mac_pkg:
//   - IMG_LANE_W=8, WGT_LANE_W=4, LANES=9, EXP_W=5.
//   - State encoding typedef seq_state_t {IDLE, RUN, DRAIN}.
//  One sub-module, sd4_tag_pipe: parameterised PIPE_DEPTH shift register of {v,f,l} with synchronous active-low clear.
//  Counters, credits and FSM stay in this module.
// TESTING
//  1. Reset: rst=0 for 2 cycles -> cfg_ready=1, credits=4, busy/op_ready/mac_issue/res_valid=0.
//  2. Single job: groups=3, outputs=2, op_valid held high, res_take pulsed on every res_valid.
//     -> 6 consecutive mac_issue cycles.
//     -> acc_clear at the tail on windows 0 and 3; res_valid on windows 2 and 5, each exactly 4 cycles after its issue.
//     -> done 1 cycle after the tail stage empties.
//  3. Credit stall: groups=1, outputs=6, res_take never asserted.
//     -> exactly 4 windows accepted, then op_ready=0.
//     -> a single res_take pulse admits exactly one more window.
//  4. Simultaneous events: res_take in the same cycle a last window is accepted -> credits unchanged.
//     res_take at credits==4 -> credits stays 4.
//  5. Gaps: op_valid toggling 1,0,1,0 -> mac_issue bubbles carry mac_image=0 and mac_weight=0; grp_cnt does not advance on gaps.
//  6. Mid-job reset: rst=0 while 2 windows are in flight -> no acc_en/res_valid afterwards; a new job starts cleanly from IDLE.
//     cfg_groups=0 -> behaves as groups=1.

Source files
------------

// File: rtl/sd4_mac_pkg.sv
// Shared widths and state encoding for the SD4 MAC operand sequencer.
package sd4_mac_pkg;

  localparam int IMG_LANE_W = 8;
  localparam int WGT_LANE_W = 4;
  localparam int LANES      = 9;
  localparam int EXP_W      = 5;
  localparam int IMG_W      = IMG_LANE_W * LANES;
  localparam int WGT_W      = WGT_LANE_W * LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/sd4_tag_pipe.sv
// Delay line for the {valid, first, last} window tags, matched to the MAC pipe latency.
module sd4_tag_pipe #(
  parameter int PIPE_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_v,
  input  logic in_f,
  input  logic in_l,
  output logic tail_v,
  output logic tail_f,
  output logic tail_l,
  output logic occupied
);

  logic [PIPE_DEPTH-1:0] v_q;
  logic [PIPE_DEPTH-1:0] f_q;
  logic [PIPE_DEPTH-1:0] l_q;

  // first/last are stored qualified by valid so a bubble never carries stale flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q <= '0;
      f_q <= '0;
      l_q <= '0;
    end else begin
      v_q[0] <= in_v;
      f_q[0] <= in_v & in_f;
      l_q[0] <= in_v & in_l;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        f_q[i] <= f_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  assign tail_v   = v_q[PIPE_DEPTH-1];
  assign tail_f   = f_q[PIPE_DEPTH-1];
  assign tail_l   = l_q[PIPE_DEPTH-1];
  assign occupied = |v_q;

endmodule

// File: rtl/sd4_mac_sequencer.sv
// Issues operand windows into the SD4 MAC pipe, tags them for the accumulator at
// the pipe tail, and throttles issue with a result-credit counter.
//
// state | meaning
// IDLE  | waiting for a job descriptor, cfg_ready high
// RUN   | accepting operand windows while result credits remain
// DRAIN | all windows issued, waiting for the tag pipe to empty
module sd4_mac_sequencer
  import sd4_mac_pkg::*;
#(
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_W      = 8,
  parameter int CREDITS    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_groups,
  input  logic [CNT_W-1:0] cfg_outputs,
  input  logic [EXP_W-1:0] cfg_exp_bias,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [IMG_W-1:0] op_image,
  input  logic [WGT_W-1:0] op_weight,
  output logic [IMG_W-1:0] mac_image,
  output logic [WGT_W-1:0] mac_weight,
  output logic [EXP_W-1:0] mac_exp_bias,
  output logic             mac_issue,
  output logic             acc_clear,
  output logic             acc_en,
  output logic             res_valid,
  input  logic             res_take,
  output logic             busy,
  output logic             done
);

  localparam int CR_W = $clog2(CREDITS + 1);
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(CREDITS);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] groups_q, outputs_q;
  logic [CNT_W-1:0] grp_cnt, out_cnt;
  logic [CR_W-1:0]  credits_q;
  logic             mac_first, mac_last;
  logic             load_cfg;
  logic             accept, last_win, last_out;
  logic             spend, take_ok;
  logic             tail_v, tail_f, tail_l, pipe_occupied, pipe_busy;

  assign op_ready  = (state_q == RUN) && (credits_q != '0);
  assign accept    = op_valid && op_ready;
  assign last_win  = (grp_cnt == groups_q - CNT_W'(1));
  assign last_out  = (out_cnt == outputs_q - CNT_W'(1));
  assign spend     = accept && last_win;
  assign take_ok   = res_take && (credits_q != CR_MAX);
  // the window just issued has not reached stage 0 yet, so it counts as in flight
  assign pipe_busy = mac_issue || pipe_occupied;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    load_cfg  = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          load_cfg = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (accept && last_win && last_out) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pipe_busy) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      groups_q     <= '0;
      outputs_q    <= '0;
      mac_exp_bias <= '0;
      grp_cnt      <= '0;
      out_cnt      <= '0;
    end else if (load_cfg) begin
      groups_q     <= (cfg_groups  == '0) ? CNT_W'(1) : cfg_groups;
      outputs_q    <= (cfg_outputs == '0) ? CNT_W'(1) : cfg_outputs;
      mac_exp_bias <= cfg_exp_bias;
      grp_cnt      <= '0;
      out_cnt      <= '0;
    end else if (accept) begin
      if (last_win) begin
        grp_cnt <= '0;
        out_cnt <= last_out ? '0 : out_cnt + CNT_W'(1);
      end else begin
        grp_cnt <= grp_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mac_issue  <= 1'b0;
      mac_first  <= 1'b0;
      mac_last   <= 1'b0;
      mac_image  <= '0;
      mac_weight <= '0;
    end else begin
      mac_issue  <= accept;
      mac_first  <= accept && (grp_cnt == '0);
      mac_last   <= accept && last_win;
      mac_image  <= accept ? op_image  : '0;
      mac_weight <= accept ? op_weight : '0;
    end
  end

  // credits survive job boundaries; only reset restores the full count
  always_ff @(posedge clk) begin
    if (!rst) begin
      credits_q <= CR_MAX;
    end else if (spend && res_take) begin
      credits_q <= credits_q;
    end else if (spend) begin
      credits_q <= credits_q - CR_W'(1);
    end else if (take_ok) begin
      credits_q <= credits_q + CR_W'(1);
    end
  end

  sd4_tag_pipe #(
    .PIPE_DEPTH(PIPE_DEPTH)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_v    (mac_issue),
    .in_f    (mac_first),
    .in_l    (mac_last),
    .tail_v  (tail_v),
    .tail_f  (tail_f),
    .tail_l  (tail_l),
    .occupied(pipe_occupied)
  );

  assign acc_en    = tail_v;
  assign acc_clear = tail_v & tail_f;
  assign res_valid = tail_v & tail_l;

endmodule

// File: tb/tb_sd4_mac_sequencer.sv
// Directed bench for sd4_mac_sequencer: reset, job flow, credit throttling, gaps, mid-job reset.
module tb_sd4_mac_sequencer;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_groups;
  logic [7:0]  cfg_outputs;
  logic [4:0]  cfg_exp_bias;
  logic        op_valid;
  logic        op_ready;
  logic [71:0] op_image;
  logic [35:0] op_weight;
  logic [71:0] mac_image;
  logic [35:0] mac_weight;
  logic [4:0]  mac_exp_bias;
  logic        mac_issue;
  logic        acc_clear;
  logic        acc_en;
  logic        res_valid;
  logic        res_take;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  sd4_mac_sequencer #(
    .PIPE_DEPTH(4),
    .CNT_W     (8),
    .CREDITS   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_groups  (cfg_groups),
    .cfg_outputs (cfg_outputs),
    .cfg_exp_bias(cfg_exp_bias),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_image    (op_image),
    .op_weight   (op_weight),
    .mac_image   (mac_image),
    .mac_weight  (mac_weight),
    .mac_exp_bias(mac_exp_bias),
    .mac_issue   (mac_issue),
    .acc_clear   (acc_clear),
    .acc_en      (acc_en),
    .res_valid   (res_valid),
    .res_take    (res_take),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] img_of(int k);
    logic [7:0] b;
    b = 8'(17 * (k + 1));
    return {9{b}};
  endfunction

  function automatic logic [35:0] wgt_of(int k);
    logic [3:0] n;
    n = 4'(k + 3);
    return {9{n}};
  endfunction

  task automatic start_job(input logic [7:0] g, input logic [7:0] o, input logic [4:0] b);
    cfg_valid    = 1'b1;
    cfg_groups   = g;
    cfg_outputs  = o;
    cfg_exp_bias = b;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL reset_op_ready got=%b exp=0", op_ready); end
    total++; if (mac_issue !== 1'b0) begin bad++; $display("FAIL reset_mac_issue got=%b exp=0", mac_issue); end
    total++; if (res_valid !== 1'b0 || acc_en !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_tail got res_valid=%b acc_en=%b done=%b exp=0", res_valid, acc_en, done);
    end
    total++; if (dut.credits_q !== 3'd4) begin bad++; $display("FAIL reset_credits got=%0d exp=4", dut.credits_q); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_job();
    int issue_cyc[6];
    int n_iss = 0, n_tail = 0, n_acc = 0;
    int done_cyc = -1, last_tail = -1;
    logic will_acc;
    start_job(8'd3, 8'd2, 5'd13);
    total++; if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      bad++; $display("FAIL job_busy got busy=%b cfg_ready=%b exp 1/0", busy, cfg_ready);
    end
    op_valid  = 1'b1;
    op_image  = img_of(0);
    op_weight = wgt_of(0);
    for (int cyc = 0; cyc < 40 && done_cyc < 0; cyc++) begin
      will_acc = op_valid && op_ready;
      res_take = res_valid;
      tick();
      if (will_acc) begin
        n_acc++;
        if (n_acc < 6) begin
          op_image  = img_of(n_acc);
          op_weight = wgt_of(n_acc);
        end else begin
          op_valid = 1'b0;
        end
      end
      if (mac_issue && n_iss < 6) begin
        total++; if (mac_image !== img_of(n_iss) || mac_weight !== wgt_of(n_iss)) begin
          bad++; $display("FAIL job_operands win=%0d got=%h/%h exp=%h/%h", n_iss, mac_image, mac_weight, img_of(n_iss), wgt_of(n_iss));
        end
        total++; if (mac_exp_bias !== 5'd13) begin bad++; $display("FAIL job_bias got=%0d exp=13", mac_exp_bias); end
        issue_cyc[n_iss] = cyc;
        n_iss++;
      end
      if (acc_en && n_tail < 6) begin
        total++; if (acc_clear !== (n_tail == 0 || n_tail == 3)) begin
          bad++; $display("FAIL job_acc_clear win=%0d got=%b", n_tail, acc_clear);
        end
        total++; if (res_valid !== (n_tail == 2 || n_tail == 5)) begin
          bad++; $display("FAIL job_res_valid win=%0d got=%b", n_tail, res_valid);
        end
        total++; if (n_tail >= n_iss || cyc != issue_cyc[n_tail] + 4) begin
          bad++; $display("FAIL job_latency win=%0d tail_cyc=%0d issued=%0d exp latency 4", n_tail, cyc, n_iss);
        end
        last_tail = cyc;
        n_tail++;
      end else if (!acc_en && (acc_clear || res_valid)) begin
        total++; bad++; $display("FAIL job_tail_without_en cyc=%0d", cyc);
      end
      if (done) done_cyc = cyc;
    end
    res_take = 1'b0;
    total++; if (n_iss != 6 || issue_cyc[5] - issue_cyc[0] != 5) begin
      bad++; $display("FAIL job_issue_run got=%0d issues exp 6 consecutive", n_iss);
    end
    total++; if (n_tail != 6) begin bad++; $display("FAIL job_tail_count got=%0d exp=6", n_tail); end
    total++; if (done_cyc < 0 || done_cyc != last_tail + 1) begin
      bad++; $display("FAIL job_done got_cyc=%0d exp_cyc=%0d", done_cyc, last_tail + 1);
    end
    tick();
    total++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL job_back_idle got cfg_ready=%b busy=%b", cfg_ready, busy);
    end
  endtask

  task automatic test_credit_stall();
    int n = 0;
    bit seen_done = 0;
    start_job(8'd1, 8'd6, 5'd2);
    op_valid  = 1'b1;
    op_image  = img_of(7);
    op_weight = wgt_of(7);
    repeat (12) begin
      tick();
      if (mac_issue) n++;
    end
    total++; if (n != 4) begin bad++; $display("FAIL stall_accepts got=%0d exp=4", n); end
    total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL stall_op_ready got=%b exp=0", op_ready); end
    n = 0;
    res_take = 1'b1;
    tick();
    res_take = 1'b0;
    if (mac_issue) n++;
    repeat (6) begin
      tick();
      if (mac_issue) n++;
    end
    total++; if (n != 1) begin bad++; $display("FAIL stall_one_more got=%0d exp=1", n); end
    res_take = 1'b1;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      tick();
      if (done) seen_done = 1;
    end
    op_valid = 1'b0;
    tick();
    tick();
    res_take = 1'b0;
    total++; if (!seen_done) begin bad++; $display("FAIL stall_done got=0 exp=1"); end
    total++; if (dut.credits_q !== 3'd4) begin bad++; $display("FAIL stall_credit_saturate got=%0d exp=4", dut.credits_q); end
  endtask

  task automatic test_simultaneous();
    bit seen_done = 0;
    start_job(8'd1, 8'd2, 5'd5);
    op_valid  = 1'b1;
    op_image  = img_of(2);
    op_weight = wgt_of(2);
    res_take  = 1'b0;
    tick();
    total++; if (dut.credits_q !== 3'd3) begin bad++; $display("FAIL simul_spend got=%0d exp=3", dut.credits_q); end
    res_take = 1'b1;
    tick();
    op_valid = 1'b0;
    res_take = 1'b0;
    total++; if (dut.credits_q !== 3'd3) begin bad++; $display("FAIL simul_both got=%0d exp=3", dut.credits_q); end
    for (int i = 0; i < 20 && !seen_done; i++) begin
      tick();
      if (done) seen_done = 1;
    end
    total++; if (!seen_done) begin bad++; $display("FAIL simul_done got=0 exp=1"); end
    res_take = 1'b1;
    tick();
    total++; if (dut.credits_q !== 3'd4) begin bad++; $display("FAIL simul_return got=%0d exp=4", dut.credits_q); end
    tick();
    res_take = 1'b0;
    total++; if (dut.credits_q !== 3'd4) begin bad++; $display("FAIL simul_saturate got=%0d exp=4", dut.credits_q); end
  endtask

  task automatic test_gaps();
    logic pat[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int   k = 0, n_tail = 0;
    bit   seen_done = 0;
    logic exp_issue;
    start_job(8'd4, 8'd1, 5'd9);
    for (int i = 0; i < 30 && !seen_done; i++) begin
      if (i < 7) begin
        op_valid  = pat[i];
        op_image  = pat[i] ? img_of(k) : '1;
        op_weight = pat[i] ? wgt_of(k) : '1;
      end else begin
        op_valid = 1'b0;
      end
      res_take = res_valid;
      tick();
      exp_issue = (i < 7) ? pat[i] : 1'b0;
      if (i < 7) begin
        total++; if (mac_issue !== exp_issue) begin
          bad++; $display("FAIL gap_issue step=%0d got=%b exp=%b", i, mac_issue, exp_issue);
        end
        total++; if (mac_image !== (exp_issue ? img_of(k) : 72'h0) || mac_weight !== (exp_issue ? wgt_of(k) : 36'h0)) begin
          bad++; $display("FAIL gap_operands step=%0d got=%h/%h", i, mac_image, mac_weight);
        end
        if (exp_issue) k++;
      end
      if (acc_en) begin
        total++; if (acc_clear !== (n_tail == 0) || res_valid !== (n_tail == 3)) begin
          bad++; $display("FAIL gap_tags tail=%0d got clear=%b res=%b", n_tail, acc_clear, res_valid);
        end
        n_tail++;
      end
      if (done) seen_done = 1;
    end
    res_take = 1'b0;
    total++; if (n_tail != 4 || !seen_done) begin
      bad++; $display("FAIL gap_complete got tails=%0d done=%0d exp 4/1", n_tail, seen_done);
    end
    tick();
  endtask

  task automatic test_midjob_reset();
    int  n_stray = 0, n_acc = 0, n_res = 0;
    bit  seen_done = 0;
    logic will_acc;
    start_job(8'd2, 8'd3, 5'd1);
    op_valid  = 1'b1;
    op_image  = img_of(3);
    op_weight = wgt_of(3);
    tick();
    tick();
    rst      = 1'b0;
    op_valid = 1'b0;
    tick();
    rst = 1'b1;
    repeat (10) begin
      tick();
      if (acc_en || res_valid) n_stray++;
    end
    total++; if (n_stray != 0) begin bad++; $display("FAIL rst_stray_tail got=%0d exp=0", n_stray); end
    total++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_idle got cfg_ready=%b busy=%b", cfg_ready, busy);
    end
    start_job(8'd0, 8'd2, 5'd4);
    op_valid = 1'b1;
    for (int i = 0; i < 30 && !seen_done; i++) begin
      will_acc = op_valid && op_ready;
      res_take = res_valid;
      tick();
      if (will_acc) begin
        n_acc++;
        if (n_acc >= 2) op_valid = 1'b0;
      end
      if (acc_en) begin
        total++; if (acc_clear !== 1'b1 || res_valid !== 1'b1) begin
          bad++; $display("FAIL grp0_tags got clear=%b res=%b exp 1/1", acc_clear, res_valid);
        end
        n_res++;
      end
      if (done) seen_done = 1;
    end
    res_take = 1'b0;
    total++; if (n_res != 2 || !seen_done) begin
      bad++; $display("FAIL grp0_complete got results=%0d done=%0d exp 2/1", n_res, seen_done);
    end
  endtask

  initial begin
    rst          = 1'b0;
    cfg_valid    = 1'b0;
    cfg_groups   = '0;
    cfg_outputs  = '0;
    cfg_exp_bias = '0;
    op_valid     = 1'b0;
    op_image     = '0;
    op_weight    = '0;
    res_take     = 1'b0;
    test_reset();
    test_single_job();
    test_credit_stall();
    test_simultaneous();
    test_gaps();
    test_midjob_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
